seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised, programmable serial bit-pattern detector; next generation of the fixed 4-bit "1011" Moore detector. It accepts one serial bit per qualified clock and compares the last PAT_LEN accepted bits against a runtime-loadable pattern. It raises a registered one-cycle `detector_out` pulse on each match and keeps a saturating match counter. It sits between a serial front end (deserialiser/line sampler) and control logic that needs pattern/framing events.

## Interface
- PAT_LEN, 4, pattern length in bits; legal range 2..16.
- DEFAULT_PAT, 4'b1011 (PAT_LEN bits), pattern value after reset.
- CNT_W, 8, width of match counter; legal range 2..32.

- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- sequence_in  input  1  serial data bit.
- in_valid  input  1  `sequence_in` is accepted on an edge only when high.
- overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping.
- pattern_load  input  1  load `pattern_in` into the pattern register.
- pattern_in  input  PAT_LEN  new pattern; bit PAT_LEN-1 is compared to the oldest bit.
- count_clear  input  1  clear `match_count`.
- detector_out  output  1  registered match pulse.
- match_count  output  CNT_W  number of matches since reset/clear, saturating.
- count_sat  output  1  high while `match_count` is all-ones.

## Operation
- Clock is `clock`. Reset is synchronous, active-high, on `reset`.
- Reset effect: pattern register = DEFAULT_PAT. History register = 0. Fill counter = 0. `detector_out` = 0. `match_count` = 0. `count_sat` = 0. Reset overrides every other input.
- History: a PAT_LEN-bit shift register. On an accepted bit: history <= {history[PAT_LEN-2:0], sequence_in}, so the newest bit is at LSB.
- Fill counter: width $clog2(PAT_LEN+1). It increments on each accepted bit and saturates at PAT_LEN. It counts valid history bits.
- Match condition, evaluated on an accepted bit using the next-history value:
  - next history == pattern register, and
  - fill counter (before increment) >= PAT_LEN-1.
- After a match:
  - overlap_en = 1: fill counter holds/saturates as normal, so the matched bits can begin the next match.
  - overlap_en = 0: fill counter <= 0, so the next match needs PAT_LEN fresh accepted bits. The history register still shifts normally.
- `overlap_en` is sampled only on the match edge. Changing it at any other time has no other effect.
- Pattern load (`pattern_load` = 1, not in reset):
  - pattern register <= `pattern_in`, fill counter <= 0, `detector_out` <= 0.
  - Any `in_valid` bit on the same edge is discarded: history does not shift and no match is evaluated.
  - `match_count` is unaffected.
- Idle edges (`in_valid` = 0, no load): history and fill counter hold. `detector_out` <= 0.
- Match counter:
  - Increments by 1 on each match edge; saturates at 2^CNT_W-1 with no wrap.
  - `count_clear` sets it to 0 and has priority over a simultaneous match. That match still pulses `detector_out` but is not counted.
- `count_sat` is a registered flag, equal to (match_count == all-ones) after each edge.
- Priority order, highest first: reset, pattern_load, accepted bit / count_clear. Count_clear is independent of loading.

## Timing
- Latency: the final pattern bit is accepted on edge N. `detector_out` = 1 from just after edge N until edge N+1, exactly one clock period. This is Moore-equivalent timing: the output is a register with no combinational path from inputs.
- `match_count` shows the incremented value in the same cycle as the `detector_out` pulse.
- Back-to-back matches (possible only with overlap_en = 1 and a periodic pattern, e.g. "11") hold `detector_out` high across consecutive cycles, and `match_count` increments on each.
- Throughput: one bit per clock. `in_valid` gaps of any length are transparent; matches span gaps.
- Reset asserted mid-pattern: partial history is discarded, and the first possible match is PAT_LEN accepted bits after reset deasserts.
- A new pattern takes effect for bits accepted on the edge after the load edge.

## Test plan
- Overlap: defaults, overlap_en = 1, in_valid = 1, bits 1,0,1,1,0,1,1 → `detector_out` pulses after bit 4 and bit 7; `match_count` = 2.
- Non-overlap: same stream, overlap_en = 0 → one pulse, after bit 4; `match_count` = 1. Then bits 0,1,1 add no pulse.
- Gaps and idle: bits 1,0,1,1 with in_valid low for 3 cycles between each bit → a single pulse, one cycle long, on the edge accepting the last bit. During the gaps `detector_out` = 0.
- Pattern load: load 4'b0110, sending bit 1 with in_valid on the load edge, then stream 0,1,1,0 → the bit sent on the load edge is ignored; one pulse after the final 0. Re-sending 1,0,1,1 gives no pulse.
- Saturation and clear: CNT_W = 2, pattern "11", overlap_en = 1, six 1s → `match_count` goes 1,2,3,3,3 and `count_sat` = 1 from the third match. Asserting `count_clear` together with a match edge → count 0, pulse still seen.
- Reset mid-operation: bits 1,0,1, then reset for 1 cycle, then bit 1 → no pulse. Then 1,0,1,1 → pulse; all outputs read 0 in the cycle after reset.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Programmable serial pattern detector. The last PAT_LEN accepted bits are
// compared against a runtime-loadable pattern. A match produces a registered
// one-cycle pulse on detector_out and bumps a saturating match counter.
// Overlapping or non-overlapping detection is selected by overlap_en, which
// only matters on the edge where a match occurs.

module seq_detector_param #(
    parameter int                 PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b1011,
    parameter int                 CNT_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic               overlap_en,
    input  logic               pattern_load,
    input  logic [PAT_LEN-1:0] pattern_in,
    input  logic               count_clear,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    // Fill counter must be able to hold the value PAT_LEN itself.
    localparam int FILL_W = $clog2(PAT_LEN + 1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [PAT_LEN-1:0] pattern_reg;
    logic [PAT_LEN-1:0] history_reg;
    logic [PAT_LEN-1:0] history_next;
    logic [PAT_LEN-1:0] bit_eq;
    logic [FILL_W-1:0]  fill_reg;
    logic [FILL_W-1:0]  fill_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               detector_reg;
    logic               sat_reg;
    logic               accept;
    logic               match;

    // A load edge swallows any bit offered on the same edge.
    assign accept       = in_valid & ~pattern_load;

    // Newest bit enters at the LSB; the oldest bit lines up with pattern MSB.
    assign history_next = {history_reg[PAT_LEN-2:0], sequence_in};

    // Per-bit equality between the prospective history and the pattern.
    generate
        for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_bit_eq
            assign bit_eq[gi] = ~(history_next[gi] ^ pattern_reg[gi]);
        end
    endgenerate

    // A match needs enough valid history: fill before this bit >= PAT_LEN-1.
    assign match = accept & (&bit_eq) & (fill_reg >= FILL_ARM);

    // Fill counter: cleared by a load or a non-overlapping match, else saturating count.
    always_comb begin
        fill_next = fill_reg;
        if (pattern_load) begin
            fill_next = '0;
        end else if (accept) begin
            if (match && !overlap_en) begin
                fill_next = '0;
            end else if (fill_reg != FILL_FULL) begin
                fill_next = fill_reg + FILL_ONE;
            end
        end
    end

    // Match counter: clear wins over a coincident match; otherwise saturating increment.
    always_comb begin
        count_next = count_reg;
        if (count_clear) begin
            count_next = '0;
        end else if (match && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CNT_ONE;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            pattern_reg  <= DEFAULT_PAT;
            history_reg  <= '0;
            fill_reg     <= '0;
            detector_reg <= 1'b0;
            count_reg    <= '0;
            sat_reg      <= 1'b0;
        end else begin
            if (pattern_load) begin
                pattern_reg <= pattern_in;
            end
            if (accept) begin
                history_reg <= history_next;
            end
            fill_reg     <= fill_next;
            detector_reg <= match;
            count_reg    <= count_next;
            sat_reg      <= (count_next == CNT_MAX);
        end
    end

    assign detector_out = detector_reg;
    assign match_count  = count_reg;
    assign count_sat    = sat_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param. Two instances share the stimulus:
// dut_a uses the default 4-bit "1011" configuration, dut_b is a 2-bit "11"
// detector with a 2-bit counter for the saturation checks. Expected outputs
// are queued when a cycle is driven and compared after the clock edge.

module tb_seq_detector_param;

    logic       clock;
    logic       reset;
    logic       sequence_in;
    logic       in_valid;
    logic       overlap_en;
    logic       pattern_load;
    logic [3:0] pattern_in;
    logic       count_clear;

    logic       det_a;
    logic [7:0] cnt_a;
    logic       sat_a;
    logic       det_b;
    logic [1:0] cnt_b;
    logic       sat_b;

    logic       sel;   // 0 = check dut_a, 1 = check dut_b

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string tag;
        logic  det;
        int    cnt;
        logic  sat;
    } exp_t;

    exp_t exp_q[$];

    seq_detector_param #(
        .PAT_LEN     (4),
        .DEFAULT_PAT (4'b1011),
        .CNT_W       (8)
    ) dut_a (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .in_valid     (in_valid),
        .overlap_en   (overlap_en),
        .pattern_load (pattern_load),
        .pattern_in   (pattern_in),
        .count_clear  (count_clear),
        .detector_out (det_a),
        .match_count  (cnt_a),
        .count_sat    (sat_a)
    );

    seq_detector_param #(
        .PAT_LEN     (2),
        .DEFAULT_PAT (2'b11),
        .CNT_W       (2)
    ) dut_b (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .in_valid     (in_valid),
        .overlap_en   (overlap_en),
        .pattern_load (pattern_load),
        .pattern_in   (pattern_in[1:0]),
        .count_clear  (count_clear),
        .detector_out (det_b),
        .match_count  (cnt_b),
        .count_sat    (sat_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        if (obs != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic step(input string tag, input logic rst, input logic v,
                        input logic b, input logic ld, input logic [3:0] pat,
                        input logic clr, input logic ed, input int ec,
                        input logic es);
        exp_t e;
        exp_t o;
        int   obs_cnt;
        logic obs_det;
        logic obs_sat;
        reset        = rst;
        in_valid     = v;
        sequence_in  = b;
        pattern_load = ld;
        pattern_in   = pat;
        count_clear  = clr;
        e.tag = tag;
        e.det = ed;
        e.cnt = ec;
        e.sat = es;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        obs_det = sel ? det_b : det_a;
        obs_cnt = sel ? int'(cnt_b) : int'(cnt_a);
        obs_sat = sel ? sat_b : sat_a;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 0, 1);
        end else begin
            o = exp_q.pop_front();
            $display("[%0t] %s dut=%0s rst=%0b v=%0b b=%0b ld=%0b clr=%0b ovl=%0b -> det=%0b cnt=%0d sat=%0b",
                     $time, o.tag, sel ? "b" : "a", rst, v, b, ld, clr, overlap_en,
                     obs_det, obs_cnt, obs_sat);
            check({o.tag, ".det"}, int'(obs_det), int'(o.det));
            check({o.tag, ".cnt"}, obs_cnt, o.cnt);
            check({o.tag, ".sat"}, int'(obs_sat), int'(o.sat));
        end
    endtask

    task automatic rst_step(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic bit_step(input string tag, input logic b, input logic ed,
                            input int ec, input logic es);
        step(tag, 1'b0, 1'b1, b, 1'b0, 4'b0000, 1'b0, ed, ec, es);
    endtask

    task automatic idle_step(input string tag, input logic ed, input int ec,
                             input logic es);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, ed, ec, es);
    endtask

    initial begin
        logic [3:0] gbits;
        reset        = 1'b1;
        sequence_in  = 1'b0;
        in_valid     = 1'b0;
        overlap_en   = 1'b1;
        pattern_load = 1'b0;
        pattern_in   = 4'b0000;
        count_clear  = 1'b0;
        sel          = 1'b0;

        // Reset state
        rst_step("reset");

        // Overlapping detection: 1,0,1,1,0,1,1 -> pulses after bits 4 and 7
        overlap_en = 1'b1;
        bit_step("ovl_b1", 1'b1, 1'b0, 0, 1'b0);
        bit_step("ovl_b2", 1'b0, 1'b0, 0, 1'b0);
        bit_step("ovl_b3", 1'b1, 1'b0, 0, 1'b0);
        bit_step("ovl_b4", 1'b1, 1'b1, 1, 1'b0);
        bit_step("ovl_b5", 1'b0, 1'b0, 1, 1'b0);
        bit_step("ovl_b6", 1'b1, 1'b0, 1, 1'b0);
        bit_step("ovl_b7", 1'b1, 1'b1, 2, 1'b0);
        idle_step("ovl_idle", 1'b0, 2, 1'b0);

        // Non-overlapping detection: same stream -> one pulse after bit 4
        rst_step("novl_rst");
        overlap_en = 1'b0;
        bit_step("novl_b1", 1'b1, 1'b0, 0, 1'b0);
        bit_step("novl_b2", 1'b0, 1'b0, 0, 1'b0);
        bit_step("novl_b3", 1'b1, 1'b0, 0, 1'b0);
        bit_step("novl_b4", 1'b1, 1'b1, 1, 1'b0);
        bit_step("novl_b5", 1'b0, 1'b0, 1, 1'b0);
        bit_step("novl_b6", 1'b1, 1'b0, 1, 1'b0);
        bit_step("novl_b7", 1'b1, 1'b0, 1, 1'b0);
        idle_step("novl_idle", 1'b0, 1, 1'b0);

        // in_valid gaps of three cycles between the bits of 1011
        rst_step("gap_rst");
        overlap_en = 1'b1;
        gbits = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            bit_step("gap_bit", gbits[i], (i == 0), (i == 0) ? 1 : 0, 1'b0);
            if (i != 0) begin
                repeat (3) idle_step("gap_idle", 1'b0, 0, 1'b0);
            end
        end
        idle_step("gap_after", 1'b0, 1, 1'b0);

        // Pattern load with a bit offered on the load edge (discarded)
        step("load_0110", 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1, 1'b0);
        bit_step("ld_b1", 1'b0, 1'b0, 1, 1'b0);
        bit_step("ld_b2", 1'b1, 1'b0, 1, 1'b0);
        bit_step("ld_b3", 1'b1, 1'b0, 1, 1'b0);
        bit_step("ld_b4", 1'b0, 1'b1, 2, 1'b0);
        bit_step("old_b1", 1'b1, 1'b0, 2, 1'b0);
        bit_step("old_b2", 1'b0, 1'b0, 2, 1'b0);
        bit_step("old_b3", 1'b1, 1'b0, 2, 1'b0);
        bit_step("old_b4", 1'b1, 1'b0, 2, 1'b0);

        // A 0 offered on a load edge must not complete 0110 three bits later
        step("reload", 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 2, 1'b0);
        bit_step("rl_b1", 1'b1, 1'b0, 2, 1'b0);
        bit_step("rl_b2", 1'b1, 1'b0, 2, 1'b0);
        bit_step("rl_b3", 1'b0, 1'b0, 2, 1'b0);

        // Reset mid-pattern discards history and restores the default pattern
        bit_step("mid_b1", 1'b1, 1'b0, 2, 1'b0);
        bit_step("mid_b2", 1'b0, 1'b0, 2, 1'b0);
        bit_step("mid_b3", 1'b1, 1'b0, 2, 1'b0);
        rst_step("mid_rst");
        bit_step("post_b0", 1'b1, 1'b0, 0, 1'b0);
        bit_step("post_b1", 1'b1, 1'b0, 0, 1'b0);
        bit_step("post_b2", 1'b0, 1'b0, 0, 1'b0);
        bit_step("post_b3", 1'b1, 1'b0, 0, 1'b0);
        bit_step("post_b4", 1'b1, 1'b1, 1, 1'b0);
        idle_step("post_idle", 1'b0, 1, 1'b0);

        // Saturation and clear on the 2-bit "11" detector with 2-bit counter
        sel        = 1'b1;
        overlap_en = 1'b1;
        rst_step("sat_rst");
        bit_step("sat_b1", 1'b1, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            bit_step("sat_bit", 1'b1, 1'b1, (k > 3) ? 3 : k, (k >= 3));
        end
        step("sat_clr", 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 0, 1'b0);
        idle_step("sat_idle", 1'b0, 0, 1'b0);
        bit_step("sat_again", 1'b1, 1'b1, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
